// File: rtl/rst_pkg.sv
// Shared types and default sizing for the staged reset sequencer.
package rst_pkg;

  typedef enum logic [1:0] {
    S_WAIT,
    S_FILT,
    S_REL,
    S_DONE
  } rst_state_t;

  localparam int DEF_N_STAGE   = 3;
  localparam int DEF_HOLD_CYC  = 16;
  localparam int DEF_LOCK_FILT = 8;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs, clears to zero on reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rst_seq.sv
// Staged reset sequencer: waits for a filtered PLL lock, then releases each
// stage reset in order with a fixed hold between releases.
module rst_seq
  import rst_pkg::*;
#(
  parameter int N_STAGE   = DEF_N_STAGE,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int LOCK_FILT = DEF_LOCK_FILT
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               locked,
  input  logic               soft_rst,
  output logic [N_STAGE-1:0] rst_out,
  output logic               ready
);

  localparam int MAX_CNT = (HOLD_CYC > LOCK_FILT) ? HOLD_CYC : LOCK_FILT;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int SW      = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] FILT_LAST  = CW'(LOCK_FILT - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(N_STAGE - 1);

  rst_state_t      state;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   stage;
  logic            lock_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (sys_clk),
    .rst (rst),
    .d   (locked),
    .q   (lock_s)
  );

  // Abort outranks every advance so a lock drop or soft restart can never
  // slip a stage release through on the same edge.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state   <= S_WAIT;
      cnt     <= '0;
      stage   <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
    end else if (state != S_WAIT && (!lock_s || soft_rst)) begin
      state   <= S_WAIT;
      cnt     <= '0;
      stage   <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (lock_s) begin
            state <= S_FILT;
            cnt   <= '0;
          end
        end
        S_FILT: begin
          if (cnt == FILT_LAST) begin
            state <= S_REL;
            cnt   <= '0;
            stage <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_REL: begin
          if (cnt == HOLD_LAST) begin
            rst_out[stage] <= 1'b0;
            cnt            <= '0;
            if (stage == STAGE_LAST) begin
              state <= S_DONE;
              ready <= 1'b1;
            end else begin
              stage <= stage + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state <= S_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: a default instance and a minimal 1/1/1 instance share stimulus
// and are checked every cycle against an edge-count timeline model.
module tb_rst_seq;

  logic       sys_clk;
  logic       rst;
  logic       locked;
  logic       soft_rst;
  logic [2:0] rst_out_a;
  logic       ready_a;
  logic [0:0] rst_out_b;
  logic       ready_b;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  rst_seq #(.N_STAGE(3), .HOLD_CYC(16), .LOCK_FILT(8)) dut_a (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .locked   (locked),
    .soft_rst (soft_rst),
    .rst_out  (rst_out_a),
    .ready    (ready_a)
  );

  rst_seq #(.N_STAGE(1), .HOLD_CYC(1), .LOCK_FILT(1)) dut_b (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .locked   (locked),
    .soft_rst (soft_rst),
    .rst_out  (rst_out_b),
    .ready    (ready_b)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Timeline model: remembers the edge at which filtering began; every release
  // is a fixed arithmetic offset from that edge.
  int edge_n  = 0;
  bit m_l1    = 0;
  bit m_l2    = 0;
  bit m_active = 0;
  int m_start = 0;

  always @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      m_l1     = 0;
      m_l2     = 0;
      m_active = 0;
    end else begin
      edge_n = edge_n + 1;
      if (m_active && (!m_l2 || soft_rst)) begin
        m_active = 0;
      end else if (!m_active && m_l2) begin
        m_active = 1;
        m_start  = edge_n;
      end
      m_l2 = m_l1;
      m_l1 = locked;
    end
  end

  function automatic logic [8:0] exp_outs(int ns, int lf, int hc);
    logic [8:0] r;
    r = {1'b0, 8'hFF};
    if (m_active) begin
      for (int k = 0; k < ns; k++)
        if (edge_n >= m_start + lf + (k + 1) * hc) r[k] = 1'b0;
      r[8] = (edge_n >= m_start + lf + ns * hc);
    end
    return r;
  endfunction

  logic [8:0] ea, eb;
  always @(negedge sys_clk) begin
    if (chk_en) begin
      ea = exp_outs(3, 8, 16);
      eb = exp_outs(1, 1, 1);
      n_checks++;
      if ({ready_a, rst_out_a} !== {ea[8], ea[2:0]})
        $display("[TB] FAIL model_a t=%0t got ready=%b rst_out=%b want ready=%b rst_out=%b",
                 $time, ready_a, rst_out_a, ea[8], ea[2:0]);
      else n_pass++;
      n_checks++;
      if ({ready_b, rst_out_b} !== {eb[8], eb[0]})
        $display("[TB] FAIL model_b t=%0t got ready=%b rst_out=%b want ready=%b rst_out=%b",
                 $time, ready_b, rst_out_b, eb[8], eb[0]);
      else n_pass++;
    end
  end

  task automatic test_reset();
    rst = 1; locked = 0; soft_rst = 0;
    repeat (3) @(negedge sys_clk);
    n_checks++;
    if ({ready_a, rst_out_a, ready_b, rst_out_b} !== 6'b0_111_0_1)
      $display("[TB] FAIL reset_state got %b want %b",
               {ready_a, rst_out_a, ready_b, rst_out_b}, 6'b0_111_0_1);
    else n_pass++;
    rst = 0;
    repeat (3) @(negedge sys_clk);
    chk_en = 1;
  endtask

  // Drives locked high after a negedge so the next posedge is E1, then checks
  // the fixed release edges of both instances.
  task automatic test_power_up();
    @(negedge sys_clk);
    locked = 1;
    for (int e = 1; e <= 62; e++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (e == 26 || e == 27 || e == 43 || e == 59) begin
        logic [3:0] want;
        want = (e == 26) ? 4'b0_111 : (e == 27) ? 4'b0_110 :
               (e == 43) ? 4'b0_100 : 4'b1_000;
        n_checks++;
        if ({ready_a, rst_out_a} !== want)
          $display("[TB] FAIL power_up_E%0d got %b want %b", e, {ready_a, rst_out_a}, want);
        else n_pass++;
      end
      if (e == 4 || e == 5) begin
        logic [1:0] want_b;
        want_b = (e == 4) ? 2'b0_1 : 2'b1_0;
        n_checks++;
        if ({ready_b, rst_out_b} !== want_b)
          $display("[TB] FAIL small_E%0d got %b want %b", e, {ready_b, rst_out_b}, want_b);
        else n_pass++;
      end
    end
  endtask

  task automatic test_lock_loss();
    @(negedge sys_clk);
    locked = 0;
    for (int e = 1; e <= 3; e++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (e >= 2) begin
        logic [3:0] want;
        want = (e == 2) ? 4'b1_000 : 4'b0_111;
        n_checks++;
        if ({ready_a, rst_out_a} !== want)
          $display("[TB] FAIL lock_loss_E%0d got %b want %b", e, {ready_a, rst_out_a}, want);
        else n_pass++;
      end
    end
    repeat (4) @(negedge sys_clk);
    locked = 1;
    for (int e = 1; e <= 60; e++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (e == 27 || e == 59) begin
        logic [3:0] want;
        want = (e == 27) ? 4'b0_110 : 4'b1_000;
        n_checks++;
        if ({ready_a, rst_out_a} !== want)
          $display("[TB] FAIL relock_E%0d got %b want %b", e, {ready_a, rst_out_a}, want);
        else n_pass++;
      end
    end
  endtask

  task automatic test_lock_glitch();
    @(negedge sys_clk);
    locked = 0;
    repeat (5) @(negedge sys_clk);
    locked = 1;
    repeat (8) @(negedge sys_clk);
    locked = 0;
    @(negedge sys_clk);
    locked = 1;
    for (int e = 10; e <= 30; e++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (e == 27) begin
        n_checks++;
        if ({ready_a, rst_out_a} !== 4'b0_111)
          $display("[TB] FAIL glitch_no_early got %b want %b", {ready_a, rst_out_a}, 4'b0_111);
        else n_pass++;
      end
    end
    repeat (45) @(negedge sys_clk);
  endtask

  // Abort on the exact edge stage 1 would release, then a full restart.
  task automatic test_soft_rst();
    @(negedge sys_clk);
    soft_rst = 1;
    @(negedge sys_clk);
    soft_rst = 0;
    for (int j = 1; j <= 99; j++) begin
      if (j == 41) soft_rst = 1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      soft_rst = 0;
      if (j == 25 || j == 41 || j == 97 || j == 98) begin
        logic [3:0] want;
        want = (j == 25) ? 4'b0_110 : (j == 41) ? 4'b0_111 :
               (j == 97) ? 4'b0_100 : 4'b1_000;
        n_checks++;
        if ({ready_a, rst_out_a} !== want)
          $display("[TB] FAIL soft_rst_j%0d got %b want %b", j, {ready_a, rst_out_a}, want);
        else n_pass++;
      end
    end
  endtask

  task automatic test_async_rst();
    @(negedge sys_clk);
    soft_rst = 1;
    @(negedge sys_clk);
    soft_rst = 0;
    repeat (30) @(negedge sys_clk);
    #2 rst = 1;
    #1;
    n_checks++;
    if ({ready_a, rst_out_a, ready_b, rst_out_b} !== 6'b0_111_0_1)
      $display("[TB] FAIL async_rst got %b want %b",
               {ready_a, rst_out_a, ready_b, rst_out_b}, 6'b0_111_0_1);
    else n_pass++;
    @(negedge sys_clk);
    rst = 0;
    for (int e = 1; e <= 60; e++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (e == 59) begin
        n_checks++;
        if ({ready_a, rst_out_a} !== 4'b1_000)
          $display("[TB] FAIL after_rst_E59 got %b want %b", {ready_a, rst_out_a}, 4'b1_000);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge sys_clk);
      if ($urandom_range(0, 39) == 0) locked = ~locked;
      soft_rst = ($urandom_range(0, 59) == 0);
    end
    @(negedge sys_clk);
    soft_rst = 0;
  endtask

  initial begin
    rst = 1; locked = 0; soft_rst = 0;
    test_reset();
    test_power_up();
    test_lock_loss();
    test_lock_glitch();
    test_soft_rst();
    test_async_rst();
    test_random();
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
